// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among N_REQ byte-stream requesters.
// It holds a packet lock until a byte marked last and sequences the TxD_start/TxD_busy handshake.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 15,
  parameter int LOCK_TIMEOUT  = 1023,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [ID_W-1:0]    grant_id,
  output logic               locked,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               err_timeout,
  input  logic               err_clr
);

  localparam int unsigned START_W = $clog2(START_TIMEOUT + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arbState;

  arbState            state;
  logic [ID_W-1:0]    rrPtr;
  logic [START_W-1:0] startCnt;
  logic [LOCK_W-1:0]  lockCnt;

  logic               ownerReq;
  logic               pickValid;
  logic [ID_W-1:0]    pickIdx;
  logic [7:0]         pickData;
  logic               pickLast;

  // Request line of the current lock owner.
  always_comb begin
    ownerReq = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_id) ownerReq = req[i];
    end
  end

  // Pick the candidate: the owner when locked, otherwise the first request after rrPtr.
  // The loop runs from the farthest offset down so the nearest request is assigned last.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand      = '0;
    pickValid = 1'b0;
    pickIdx   = '0;
    if (locked) begin
      pickValid = ownerReq;
      pickIdx   = grant_id;
    end else begin
      for (int off = N_REQ; off >= 1; off--) begin
        cand = ID_W'((int'(rrPtr) + off) % N_REQ);
        if (req[cand]) begin
          pickValid = 1'b1;
          pickIdx   = cand;
        end
      end
    end
  end

  // Byte and last flag of the picked requester.
  always_comb begin
    pickData = 8'h00;
    pickLast = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == pickIdx) begin
        pickData = req_data[8*i +: 8];
        pickLast = req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rrPtr       <= ID_W'(N_REQ - 1);
      startCnt    <= '0;
      lockCnt     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
    end else begin
      req_ack <= '0;
      // A timeout raised in the same cycle overrides this clear below.
      if (err_clr) err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (pickValid && !tx_busy) begin
            tx_data  <= pickData;
            grant_id <= pickIdx;
            req_ack  <= N_REQ'(1) << pickIdx;
            tx_start <= 1'b1;
            locked   <= ~pickLast;
            rrPtr    <= pickIdx;
            lockCnt  <= '0;
            startCnt <= '0;
            state    <= LAUNCH;
          end else if (locked && !ownerReq) begin
            if (lockCnt == LOCK_W'(LOCK_TIMEOUT - 1)) begin
              locked  <= 1'b0;
              lockCnt <= '0;
            end else begin
              lockCnt <= lockCnt + LOCK_W'(1);
            end
          end
        end

        LAUNCH: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            startCnt <= '0;
            state    <= WAIT_DONE;
          end else if (startCnt == START_W'(START_TIMEOUT - 1)) begin
            // Transmitter never answered: drop the byte and free the channel.
            tx_start    <= 1'b0;
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            startCnt    <= '0;
            state       <= IDLE;
          end else begin
            startCnt <= startCnt + START_W'(1);
          end
        end

        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet
// traffic checked against a transaction-level round-robin/lock model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   req;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqLast;
  logic [N-1:0]   reqAck;
  logic [1:0]     grantId;
  logic           locked;
  logic           txStart;
  logic [7:0]     txData;
  logic           txBusy;
  logic           errTimeout;
  logic           errClr;

  int checks = 0;
  int errors = 0;

  bit autoUart = 1'b0;
  int uPhase   = 0;
  int uCnt     = 0;

  uart_tx_arbiter #(
    .N_REQ(N),
    .START_TIMEOUT(15),
    .LOCK_TIMEOUT(1023)
  ) dut (
    .clk(clk),
    .reset_n(rstN),
    .req(req),
    .req_data(reqData),
    .req_last(reqLast),
    .req_ack(reqAck),
    .grant_id(grantId),
    .locked(locked),
    .tx_start(txStart),
    .tx_data(txData),
    .tx_busy(txBusy),
    .err_timeout(errTimeout),
    .err_clr(errClr)
  );

  always #5 clk = ~clk;

  // Stand-in for uart_tx: answers tx_start with busy after 0..3 cycles, busy for 2..6 cycles.
  always @(negedge clk) begin
    if (autoUart) begin
      case (uPhase)
        0: if (txStart && !txBusy) begin uCnt = $urandom_range(0, 3); uPhase = 1; end
        1: if (uCnt == 0) begin txBusy = 1'b1; uCnt = $urandom_range(2, 6); uPhase = 2; end
           else uCnt--;
        default: if (uCnt == 0) begin txBusy = 1'b0; uPhase = 0; end
                 else uCnt--;
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic setReq(input int i, input bit on, input logic [7:0] d, input bit last);
    req[i]            = on;
    reqData[8*i +: 8] = d;
    reqLast[i]        = last;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (uPhase == 0 && !txStart && !txBusy) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL drain got uart_phase %0d want 0", uPhase); end
    autoUart = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rstN = 1'b0; req = '0; reqData = '0; reqLast = '0; txBusy = 1'b0; errClr = 1'b0;
    step();
    step();
    checks++; if (reqAck !== 4'b0000) begin errors++; $display("FAIL reset_req_ack got %b want 0000", reqAck); end
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", txStart); end
    checks++; if (txData !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", txData); end
    checks++; if (grantId !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grantId); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (errTimeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", errTimeout); end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_single_request();
    setReq(1, 1'b1, 8'h41, 1'b1);
    step();
    checks++; if (reqAck !== 4'b0010) begin errors++; $display("FAIL single_ack got %b want 0010", reqAck); end
    checks++; if (grantId !== 2'd1) begin errors++; $display("FAIL single_grant got %0d want 1", grantId); end
    checks++; if (txData !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", txData); end
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", txStart); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_locked got %b want 0", locked); end
    setReq(1, 1'b0, 8'h41, 1'b1);
    step();
    checks++; if (reqAck !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse got %b want 0000", reqAck); end
    step();
    step();
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL single_start_held got %b want 1", txStart); end
    txBusy = 1'b1;
    step();
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL single_start_drop got %b want 0", txStart); end
    step();
    step();
    txBusy = 1'b0;
    step();
    step();
    checks++; if (txData !== 8'h41) begin errors++; $display("FAIL single_data_stable got %h want 41", txData); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_locked_end got %b want 0", locked); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int got;
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 8'(8'h10 + i), 1'b1);
    autoUart = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
      step();
      if (reqAck !== 4'b0000) begin
        checks++;
        if (reqAck !== (4'b0001 << order[got])) begin
          errors++; $display("FAIL rr_order[%0d] got %b want %b", got, reqAck, 4'b0001 << order[got]);
        end
        checks++;
        if (txData !== 8'(8'h10 + order[got])) begin
          errors++; $display("FAIL rr_data[%0d] got %h want %h", got, txData, 8'(8'h10 + order[got]));
        end
        got++;
      end
    end
    req = '0;
    checks++; if (got != 5) begin errors++; $display("FAIL rr_count got %0d want 5", got); end
    drain();
  endtask

  task automatic test_packet_lock();
    logic [7:0] bytesA[3] = '{8'hA0, 8'hA1, 8'hA2};
    int  n2;
    bit  seen0, lockBad;
    n2 = 0; seen0 = 1'b0; lockBad = 1'b0;
    setReq(0, 1'b1, 8'h0F, 1'b1);
    setReq(2, 1'b1, bytesA[0], 1'b0);
    autoUart = 1'b1;
    for (int cyc = 0; cyc < 400 && !seen0; cyc++) begin
      step();
      if (reqAck !== 4'b0000) begin
        if (n2 < 3) begin
          checks++;
          if (reqAck !== 4'b0100) begin errors++; $display("FAIL lock_ack[%0d] got %b want 0100", n2, reqAck); end
          checks++;
          if (txData !== bytesA[n2]) begin errors++; $display("FAIL lock_data[%0d] got %h want %h", n2, txData, bytesA[n2]); end
          checks++;
          if (locked !== (n2 < 2)) begin errors++; $display("FAIL lock_flag[%0d] got %b want %b", n2, locked, n2 < 2); end
          n2++;
          if (n2 < 3) setReq(2, 1'b1, bytesA[n2], n2 == 2);
          else setReq(2, 1'b0, 8'h00, 1'b0);
        end else begin
          checks++;
          if (reqAck !== 4'b0001) begin errors++; $display("FAIL lock_after got %b want 0001", reqAck); end
          seen0 = 1'b1;
          setReq(0, 1'b0, 8'h0F, 1'b1);
        end
      end else if (n2 >= 1 && n2 < 3 && locked !== 1'b1) begin
        lockBad = 1'b1;
      end
    end
    checks++; if (!seen0) begin errors++; $display("FAIL lock_req0_served got 0 want 1"); end
    checks++; if (lockBad) begin errors++; $display("FAIL lock_held got 0 want 1"); end
    req = '0;
    drain();
  endtask

  task automatic test_start_timeout();
    int highCnt;
    txBusy = 1'b0;
    setReq(1, 1'b1, 8'h77, 1'b1);
    step();
    checks++; if (reqAck !== 4'b0010) begin errors++; $display("FAIL to_ack got %b want 0010", reqAck); end
    setReq(1, 1'b0, 8'h77, 1'b1);
    highCnt = (txStart === 1'b1) ? 1 : 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (txStart === 1'b1) highCnt++;
    end
    checks++; if (highCnt != 15) begin errors++; $display("FAIL to_start_cycles got %0d want 15", highCnt); end
    checks++; if (errTimeout !== 1'b0) begin errors++; $display("FAIL to_err_early got %b want 0", errTimeout); end
    step();
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL to_start_drop got %b want 0", txStart); end
    checks++; if (errTimeout !== 1'b1) begin errors++; $display("FAIL to_err_set got %b want 1", errTimeout); end
    errClr = 1'b1;
    step();
    errClr = 1'b0;
    checks++; if (errTimeout !== 1'b0) begin errors++; $display("FAIL to_err_clr got %b want 0", errTimeout); end
    setReq(2, 1'b1, 8'h78, 1'b0);
    step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_lock_set got %b want 1", locked); end
    setReq(2, 1'b0, 8'h78, 1'b0);
    errClr = 1'b1;
    for (int k = 0; k < 14; k++) step();
    step();
    checks++; if (errTimeout !== 1'b1) begin errors++; $display("FAIL to_set_wins got %b want 1", errTimeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_unlock got %b want 0", locked); end
    step();
    checks++; if (errTimeout !== 1'b0) begin errors++; $display("FAIL to_clr_after got %b want 0", errTimeout); end
    errClr = 1'b0;
  endtask

  task automatic test_lock_timeout();
    bit early;
    early = 1'b0;
    setReq(1, 1'b1, 8'h55, 1'b0);
    step();
    checks++; if (reqAck !== 4'b0010) begin errors++; $display("FAIL lt_ack got %b want 0010", reqAck); end
    setReq(1, 1'b0, 8'h55, 1'b0);
    setReq(3, 1'b1, 8'h33, 1'b1);
    txBusy = 1'b1;
    step();
    txBusy = 1'b0;
    step();
    for (int k = 0; k < 1022; k++) begin
      step();
      if (reqAck !== 4'b0000 || locked !== 1'b1) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL lt_early_release got 1 want 0"); end
    step();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lt_unlock got %b want 0", locked); end
    checks++; if (reqAck !== 4'b0000) begin errors++; $display("FAIL lt_no_ack_yet got %b want 0000", reqAck); end
    step();
    checks++; if (reqAck !== 4'b1000) begin errors++; $display("FAIL lt_grant3 got %b want 1000", reqAck); end
    checks++; if (txData !== 8'h33) begin errors++; $display("FAIL lt_data got %h want 33", txData); end
    setReq(3, 1'b0, 8'h33, 1'b1);
    autoUart = 1'b1;
    drain();
  endtask

  task automatic test_reset_midflight();
    txBusy = 1'b0;
    setReq(2, 1'b1, 8'h99, 1'b0);
    step();
    checks++; if (reqAck !== 4'b0100) begin errors++; $display("FAIL mr_ack got %b want 0100", reqAck); end
    setReq(2, 1'b0, 8'h99, 1'b0);
    txBusy = 1'b1;
    step();
    step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mr_pre_locked got %b want 1", locked); end
    rstN = 1'b0;
    #1;
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL mr_start got %b want 0", txStart); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mr_locked got %b want 0", locked); end
    checks++; if (reqAck !== 4'b0000) begin errors++; $display("FAIL mr_ack_clr got %b want 0000", reqAck); end
    checks++; if (txData !== 8'h00) begin errors++; $display("FAIL mr_data got %h want 00", txData); end
    step();
    rstN = 1'b1;
    txBusy = 1'b0;
    setReq(0, 1'b1, 8'h01, 1'b1);
    setReq(2, 1'b1, 8'h02, 1'b1);
    step();
    checks++; if (reqAck !== 4'b0001) begin errors++; $display("FAIL mr_first_grant got %b want 0001", reqAck); end
    req = '0;
    autoUart = 1'b1;
    drain();
  endtask

  task automatic test_random();
    logic [8:0] qMem[N][12];
    int qHead[N], qLen[N], gap[N];
    int lastWin, owner, totalBytes, acks, id, expId, np, len;
    bit ownerValid, allDone, isLast;
    rstN = 1'b0; req = '0;
    step();
    rstN = 1'b1;
    totalBytes = 0;
    for (int i = 0; i < N; i++) begin
      qHead[i] = 0; qLen[i] = 0;
      gap[i] = $urandom_range(0, 2);
      np = $urandom_range(2, 3);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          qMem[i][qLen[i]] = {(b == len - 1), 8'($urandom)};
          qLen[i]++;
          totalBytes++;
        end
      end
    end
    lastWin = N - 1; owner = 0; ownerValid = 1'b0; acks = 0;
    autoUart = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      // Requesters: present the queue head unless pausing.
      for (int i = 0; i < N; i++) begin
        if (gap[i] > 0) begin req[i] = 1'b0; gap[i]--; end
        else if (qHead[i] < qLen[i]) setReq(i, 1'b1, qMem[i][qHead[i]][7:0], qMem[i][qHead[i]][8]);
        else req[i] = 1'b0;
      end
      step();
      if (reqAck !== 4'b0000) begin
        id = -1;
        for (int i = 0; i < N; i++) if (reqAck[i] === 1'b1) id = i;
        checks++;
        if (!$onehot(reqAck)) begin errors++; $display("FAIL rnd_onehot got %b want one-hot", reqAck); end
        expId = -1;
        if (ownerValid) expId = owner;
        else for (int k = 1; k <= N; k++) if (expId < 0 && req[(lastWin + k) % N]) expId = (lastWin + k) % N;
        checks++;
        if (id != expId) begin errors++; $display("FAIL rnd_winner got %0d want %0d", id, expId); end
        if (id >= 0 && qHead[id] < qLen[id]) begin
          isLast = qMem[id][qHead[id]][8];
          checks++;
          if (txData !== qMem[id][qHead[id]][7:0]) begin
            errors++; $display("FAIL rnd_data got %h want %h", txData, qMem[id][qHead[id]][7:0]);
          end
          checks++;
          if (locked !== !isLast) begin errors++; $display("FAIL rnd_locked got %b want %b", locked, !isLast); end
          checks++;
          if (grantId !== 2'(id)) begin errors++; $display("FAIL rnd_grant_id got %0d want %0d", grantId, id); end
          lastWin = id; owner = id; ownerValid = !isLast;
          qHead[id]++;
          acks++;
          gap[id] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
      end
      allDone = 1'b1;
      for (int i = 0; i < N; i++) if (qHead[i] < qLen[i]) allDone = 1'b0;
      if (allDone) break;
    end
    req = '0;
    checks++;
    if (acks != totalBytes) begin errors++; $display("FAIL rnd_byte_count got %0d want %0d", acks, totalBytes); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_packet_lock();
    test_start_timeout();
    test_lock_timeout();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
